// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage: issues one fetch at a time, holds the instruction for decode,
// and applies jump/branch redirects. Define FETCH_REDIRECT_CNT_EN to add a saturating redirect counter.
module fetch_pc_unit #(
  parameter int unsigned       ADDR_W   = 20,
  parameter int unsigned       INSTR_W  = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  offset_ext,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [15:0]        redirect_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc, pc_d;
  logic [ADDR_W-1:0]   last_pc, last_pc_d;
  logic                flush, flush_d;
  logic                imem_req_d;
  logic [ADDR_W-1:0]   imem_addr_d;
  logic                instr_valid_d;
  logic [INSTR_W-1:0]  instr_out_d;
  logic [ADDR_W-1:0]   pc_out_d;

  logic                redir;
  logic                hs;
  logic [ADDR_W-1:0]   branch_base;
  logic [ADDR_W-1:0]   target;

  assign redir = jump | branch_taken;
  assign hs    = (state_q == HOLD) && instr_valid && instr_ready;
  // A branch in the handshake cycle is relative to the instruction being accepted.
  assign branch_base = hs ? pc_out : last_pc;
  assign target      = jump ? jump_target : branch_base + offset_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc          <= RESET_PC;
      last_pc     <= RESET_PC;
      flush       <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      last_pc     <= last_pc_d;
      flush       <= flush_d;
      imem_req    <= imem_req_d;
      imem_addr   <= imem_addr_d;
      instr_valid <= instr_valid_d;
      instr_out   <= instr_out_d;
      pc_out      <= pc_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!redir && !stall) state_d = REQ;
      REQ:  if (imem_ready) state_d = (flush || redir) ? IDLE : HOLD;
      HOLD: if (hs || redir) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d          = pc;
    last_pc_d     = last_pc;
    flush_d       = flush;
    imem_addr_d   = imem_addr;
    instr_out_d   = instr_out;
    pc_out_d      = pc_out;
    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == HOLD);

    if (hs) begin
      last_pc_d = pc_out;
      pc_d      = pc + ADDR_W'(PC_STEP);
    end
    if (redir) pc_d = target;

    if (state_q == REQ) begin
      if (imem_ready)  flush_d = 1'b0;
      else if (redir)  flush_d = 1'b1;
    end

    if (state_q == IDLE && state_d == REQ) imem_addr_d = pc;

    if (state_q == REQ && state_d == HOLD) begin
      instr_out_d = imem_rdata;
      pc_out_d    = pc;
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      redirect_cnt <= '0;
    else if (redir && redirect_cnt != 16'hFFFF)
      redirect_cnt <= redirect_cnt + 16'd1;
  end
`endif

endmodule
